// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Shared definitions for the UART transmit path.
//   - UART timing constants used by anything that needs frame timing.
//   - State encoding of the uart_tx_fifo drain FSM (2-bit, fixed values so
//     the exported debug state is stable for checkers and waveforms).
// No ports: package only.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int CLK_FREQ   = 100_000_000;
    localparam int BAUD       = 115200;
    localparam int OVERSAMPLE = 16;

    // Clock cycles per bit and per 10-bit frame (start + 8 data + stop).
    localparam int BAUD_DIV     = CLK_FREQ / BAUD;
    localparam int FRAME_CYCLES = BAUD_DIV * 10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_IDLE = 2'd3
    } tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
//
// Bundle of every data/handshake signal of uart_tx_fifo.
//
// Handshake rules:
//   Producer side: a byte moves on a rising clk edge where in_valid and
//   in_ready are both 1. in_ready may drop at any time without a transfer;
//   the producer keeps in_data stable while in_valid is high and not taken.
//   UART side: uart_write_en is a one-cycle strobe; uart_data_in is valid
//   in that cycle and holds until the next strobe. uart_write_busy is owned
//   by the UART and must rise after each strobe and fall when the frame ends.
//
// Signals:
//   in_data/in_valid/in_ready   producer byte stream
//   flush                       synchronous clear of stored bytes
//   uart_data_in/uart_write_en  byte and strobe toward the UART
//   uart_write_busy             UART frame in progress
//   count/empty/full            fill level
//   stall_err                   sticky: UART never went busy after a strobe
//   state                       drain FSM state (debug)
//
// Modports: master = environment (producer + UART), slave = uart_tx_fifo.
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [7:0]      in_data;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic [7:0]      uart_data_in;
    logic            uart_write_en;
    logic            uart_write_busy;
    logic [ADDR_W:0] count;
    logic            empty;
    logic            full;
    logic            stall_err;
    tx_state_e       state;

    modport master (
        output in_data, in_valid, flush, uart_write_busy,
        input  in_ready, uart_data_in, uart_write_en,
               count, empty, full, stall_err, state
    );

    modport slave (
        input  in_data, in_valid, flush, uart_write_busy,
        output in_ready, uart_data_in, uart_write_en,
               count, empty, full, stall_err, state
    );

endinterface : uart_tx_fifo_if

// File: rtl/uart_tx_fifo_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//
// Single-clock FIFO with a combinational read port (rd_data always shows the
// oldest entry) and a synchronous flush.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   flush      clears pointers and count on the next edge; overrides wr/rd
//   wr_en      write wr_data (ignored when full or flushing)
//   wr_data    data to store
//   rd_en      drop the oldest entry (ignored when empty or flushing)
//   rd_data    oldest entry
//   count      entries stored, 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic do_push;
    logic do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (ADDR_W + 1)'(DEPTH));
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Flush has priority over both ports so a flushing cycle never moves data.
    assign do_push = wr_en && !full && !flush;
    assign do_pop  = rd_en && !empty && !flush;

    always_comb begin
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : sync_fifo

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Transmit buffer in front of a UART. Bytes from the producer are queued in a
// DEPTH-entry FIFO and handed to the UART one per frame: a byte is popped only
// while the UART is not busy, presented on uart_data_in with a one-cycle
// uart_write_en strobe, and the FSM then waits for uart_write_busy to rise and
// fall before the next pop. If busy never rises within BUSY_TIMEOUT cycles the
// byte is abandoned and stall_err is set (cleared only by rst).
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   uart_tx_fifo_if.slave (producer handshake, flush, UART side,
//         fill level, stall_err, debug state)
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);

    // Timer only needs to reach BUSY_TIMEOUT-1.
    localparam int TMR_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

    tx_state_e        state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       data_q, data_d;
    logic             write_en_q, write_en_d;
    logic             stall_q, stall_d;

    logic             in_ready;
    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_rd_data;
    logic [ADDR_W:0]  fifo_count;
    logic             fifo_empty;
    logic             fifo_full;

    // Flush blocks intake in the same cycle so a byte is never accepted and
    // then silently discarded by the clear.
    assign in_ready  = !fifo_full && !bus.flush;
    assign fifo_push = bus.in_valid && in_ready;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .WIDTH  (8),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .wr_en   (fifo_push),
        .wr_data (bus.in_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        data_d     = data_q;
        stall_d    = stall_q;
        write_en_d = 1'b0;
        fifo_pop   = 1'b0;

        case (state_q)
            // The busy guard also covers a UART still mid-frame after our
            // own reset, since the UART itself is not reset.
            IDLE: begin
                if (!fifo_empty && !bus.uart_write_busy && !bus.flush) begin
                    fifo_pop   = 1'b1;
                    data_d     = fifo_rd_data;
                    write_en_d = 1'b1;
                    state_d    = ISSUE;
                end
            end

            ISSUE: begin
                timer_d = '0;
                state_d = WAIT_BUSY;
            end

            WAIT_BUSY: begin
                if (bus.uart_write_busy) begin
                    state_d = WAIT_IDLE;
                end else if (timer_q == TMR_W'(BUSY_TIMEOUT - 1)) begin
                    // UART ignored the strobe: give the byte up and flag it.
                    stall_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            WAIT_IDLE: begin
                if (!bus.uart_write_busy) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            data_q     <= 8'h00;
            write_en_q <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            data_q     <= data_d;
            write_en_q <= write_en_d;
            stall_q    <= stall_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.uart_data_in  = data_q;
    assign bus.uart_write_en = write_en_q;
    assign bus.count         = fifo_count;
    assign bus.empty         = fifo_empty;
    assign bus.full          = fifo_full;
    assign bus.stall_err     = stall_q;
    assign bus.state         = state_q;

endmodule : uart_tx_fifo
